// File: rtl/sbus_router_pkg.sv
// Shared definitions for the system-bus router: bus widths, slave-select
// field bounds and the router FSM state encoding.
package sbus_router_pkg;

  localparam int MemBus     = 32;
  localparam int MemAddrBus = 32;

  localparam int SBUS_SEL_MSB = 31;
  localparam int SBUS_SEL_LSB = 28;
  localparam int SelW         = SBUS_SEL_MSB - SBUS_SEL_LSB + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/sbus_wdt.sv
// Read-response watchdog. Counts enabled, non-frozen cycles from a clear and
// flags the cycle in which the count sits at TIMEOUT-1. The count saturates
// there rather than wrapping.
module sbus_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic frz_i,
  output logic expired_o
);

  localparam int CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count silent cycles up to the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !frz_i && (cnt_q != CntLast)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CntLast);

endmodule

// File: rtl/sbus_router.sv
// Single-master, N-slave system-bus router with one outstanding read.
// Commands pass through combinationally to the slave picked by the address
// top nibble; read responses come back combinationally from the latched
// slave. Unmapped reads get an error response from the router itself.
// Build option SBUS_TIMEOUT_EN adds a watchdog that turns a silent slave
// into an error response after TIMEOUT waiting cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no read outstanding; commands forwarded, stray rsps drained
// S_WAIT | read issued to sel_q; its response is passed to the master
// S_ERR  | router-generated error response held until master accepts
module sbus_router
  import sbus_router_pkg::*;
#(
  parameter int N_SLV   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MemBus-1:0]       m_cmd_wdata,
  input  logic [MemAddrBus-1:0]   m_cmd_addr,
  input  logic                    m_cmd_we,
  input  logic [3:0]              m_cmd_wem,
  input  logic                    m_cmd_valid,
  output logic                    m_cmd_ready,
  output logic [MemBus-1:0]       m_rsp_rdata,
  output logic                    m_rsp_valid,
  input  logic                    m_rsp_ready,
  output logic                    m_rsp_error,
  output logic [MemBus-1:0]       s_cmd_wdata,
  output logic [MemAddrBus-1:0]   s_cmd_addr,
  output logic                    s_cmd_we,
  output logic [3:0]              s_cmd_wem,
  output logic [N_SLV-1:0]        s_cmd_valid,
  input  logic [N_SLV-1:0]        s_cmd_ready,
  input  logic [N_SLV*MemBus-1:0] s_rsp_rdata,
  input  logic [N_SLV-1:0]        s_rsp_valid,
  output logic [N_SLV-1:0]        s_rsp_ready,
  input  logic [N_SLV-1:0]        s_rsp_error
);

  if (N_SLV < 1 || N_SLV > 16 || TIMEOUT < 2) begin : g_param_chk
    $error("sbus_router: N_SLV must be 1..16 and TIMEOUT must be >= 2");
  end

  localparam logic [SelW:0] NSlvW = (SelW + 1)'(N_SLV);

  state_e          state_q, state_d;
  logic [SelW-1:0] sel_q, sel_d;
  logic [SelW-1:0] sel;
  logic            mapped;
  logic            sel_rdy;
  logic            sq_valid;
  logic            sq_error;
  logic [MemBus-1:0] sq_rdata;
  logic            wdt_exp;

  assign sel    = m_cmd_addr[SBUS_SEL_MSB:SBUS_SEL_LSB];
  assign mapped = ({1'b0, sel} < NSlvW);

  assign s_cmd_wdata = m_cmd_wdata;
  assign s_cmd_addr  = m_cmd_addr;
  assign s_cmd_we    = m_cmd_we;
  assign s_cmd_wem   = m_cmd_wem;

  // Pick the addressed slave's cmd ready and the latched slave's response.
  always_comb begin
    sel_rdy  = 1'b0;
    sq_valid = 1'b0;
    sq_error = 1'b0;
    sq_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel == SelW'(i)) begin
        sel_rdy = s_cmd_ready[i];
      end
      if (sel_q == SelW'(i)) begin
        sq_valid = s_rsp_valid[i];
        sq_error = s_rsp_error[i];
        sq_rdata = s_rsp_rdata[i*MemBus +: MemBus];
      end
    end
  end

  // Next state and all handshake outputs.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    m_cmd_ready = 1'b0;
    s_cmd_valid = '0;
    s_rsp_ready = '1;
    m_rsp_valid = 1'b0;
    m_rsp_error = 1'b0;
    m_rsp_rdata = '0;
    case (state_q)
      S_IDLE: begin
        m_cmd_ready = m_cmd_valid & (~mapped | sel_rdy);
        for (int i = 0; i < N_SLV; i++) begin
          if (mapped && (sel == SelW'(i))) begin
            s_cmd_valid[i] = m_cmd_valid;
          end
        end
        if (m_cmd_ready && !m_cmd_we) begin
          if (mapped) begin
            state_d = S_WAIT;
            sel_d   = sel;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_WAIT: begin
        s_rsp_ready = '0;
        for (int i = 0; i < N_SLV; i++) begin
          if (sel_q == SelW'(i)) begin
            s_rsp_ready[i] = m_rsp_ready;
          end
        end
        m_rsp_valid = sq_valid;
        m_rsp_error = sq_error;
        m_rsp_rdata = sq_rdata;
        if (sq_valid && m_rsp_ready) begin
          state_d = S_IDLE;
        end else if (!sq_valid && wdt_exp) begin
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        m_rsp_valid = 1'b1;
        m_rsp_error = 1'b1;
        if (m_rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched slave index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

`ifdef SBUS_TIMEOUT_EN
  logic wdt_clr;
  logic wdt_en;
  logic wdt_frz;

  // Restart on every new read; count only cycles where the slave is silent.
  assign wdt_clr = (state_q == S_IDLE) && (state_d == S_WAIT);
  assign wdt_en  = (state_q == S_WAIT) && !sq_valid;
  assign wdt_frz = sq_valid && !m_rsp_ready;

  sbus_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wdt_clr),
    .en_i     (wdt_en),
    .frz_i    (wdt_frz),
    .expired_o(wdt_exp)
  );
`else
  assign wdt_exp = 1'b0;
`endif

endmodule

// File: tb/tb_sbus_router.sv
module tb_sbus_router;

  localparam int NS = 4;
  localparam int TO = 8;
`ifdef SBUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     m_cmd_wdata;
  logic [31:0]     m_cmd_addr;
  logic            m_cmd_we;
  logic [3:0]      m_cmd_wem;
  logic            m_cmd_valid;
  logic            m_cmd_ready;
  logic [31:0]     m_rsp_rdata;
  logic            m_rsp_valid;
  logic            m_rsp_ready;
  logic            m_rsp_error;
  logic [31:0]     s_cmd_wdata;
  logic [31:0]     s_cmd_addr;
  logic            s_cmd_we;
  logic [3:0]      s_cmd_wem;
  logic [NS-1:0]   s_cmd_valid;
  logic [NS-1:0]   s_cmd_ready;
  logic [NS*32-1:0] s_rsp_rdata;
  logic [NS-1:0]   s_rsp_valid;
  logic [NS-1:0]   s_rsp_ready;
  logic [NS-1:0]   s_rsp_error;

  always #5 clk = ~clk;

  sbus_router #(.N_SLV(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cmd_wdata(m_cmd_wdata), .m_cmd_addr(m_cmd_addr), .m_cmd_we(m_cmd_we),
    .m_cmd_wem(m_cmd_wem), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_rsp_rdata(m_rsp_rdata), .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_error(m_rsp_error),
    .s_cmd_wdata(s_cmd_wdata), .s_cmd_addr(s_cmd_addr), .s_cmd_we(s_cmd_we),
    .s_cmd_wem(s_cmd_wem), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_rsp_rdata(s_rsp_rdata), .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_rsp_error(s_rsp_error)
  );

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: what the router currently owes the master.
  bit m_busy  = 1'b0;   // a read is outstanding at slave m_slv
  bit m_errp  = 1'b0;   // an error response is owed
  int m_slv   = 0;
  int m_silent = 0;     // silent cycles seen for the outstanding read

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    logic        e_cr, e_rv, e_re;
    logic [31:0] e_rdata;
    logic [NS-1:0] e_scv, e_srr;
    int slot;
    slot    = int'(m_cmd_addr[31:28]);
    e_cr    = 1'b0;
    e_rv    = 1'b0;
    e_re    = 1'b0;
    e_rdata = '0;
    e_scv   = '0;
    e_srr   = '1;
    if (m_errp) begin
      e_rv = 1'b1;
      e_re = 1'b1;
    end else if (m_busy) begin
      e_srr        = '0;
      e_srr[m_slv] = m_rsp_ready;
      e_rv         = s_rsp_valid[m_slv];
      e_re         = s_rsp_error[m_slv];
      e_rdata      = s_rsp_rdata[32*m_slv +: 32];
    end else if (slot < NS) begin
      e_cr = m_cmd_valid & s_cmd_ready[slot];
      if (m_cmd_valid) e_scv[slot] = 1'b1;
    end else begin
      e_cr = m_cmd_valid;
    end
    chk("m_cmd_ready", 64'(m_cmd_ready), 64'(e_cr));
    chk("s_cmd_valid", 64'(s_cmd_valid), 64'(e_scv));
    chk("s_rsp_ready", 64'(s_rsp_ready), 64'(e_srr));
    chk("m_rsp_valid", 64'(m_rsp_valid), 64'(e_rv));
    chk("m_rsp_error", 64'(m_rsp_error), 64'(e_re));
    chk("m_rsp_rdata", 64'(m_rsp_rdata), 64'(e_rdata));
    chk("s_cmd_bcast", {s_cmd_addr, s_cmd_wdata}, {m_cmd_addr, m_cmd_wdata});
    chk("s_cmd_we_wem", 64'({s_cmd_we, s_cmd_wem}), 64'({m_cmd_we, m_cmd_wem}));
  endtask

  task automatic model_next();
    int slot;
    slot = int'(m_cmd_addr[31:28]);
    if (rst) begin
      m_busy = 1'b0;
      m_errp = 1'b0;
      m_silent = 0;
    end else if (m_errp) begin
      if (m_rsp_ready) m_errp = 1'b0;
    end else if (m_busy) begin
      if (s_rsp_valid[m_slv]) begin
        if (m_rsp_ready) m_busy = 1'b0;
      end else if (TMO_EN && (m_silent == TO - 1)) begin
        m_busy = 1'b0;
        m_errp = 1'b1;
      end else begin
        m_silent++;
      end
    end else if (m_cmd_valid && !m_cmd_we) begin
      if (slot >= NS) begin
        m_errp = 1'b1;
      end else if (s_cmd_ready[slot]) begin
        m_busy   = 1'b1;
        m_slv    = slot;
        m_silent = 0;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_compare();
  endtask

  task automatic adv();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    adv();
  endtask

  task automatic idle_in();
    m_cmd_valid = 1'b0;
    m_cmd_we    = 1'b0;
    m_cmd_addr  = '0;
    m_cmd_wdata = '0;
    m_cmd_wem   = '0;
    s_cmd_ready = '0;
    s_rsp_valid = '0;
    s_rsp_rdata = '0;
    s_rsp_error = '0;
    m_rsp_ready = 1'b1;
  endtask

  task automatic issue_read(input logic [31:0] addr);
    m_cmd_valid = 1'b1;
    m_cmd_we    = 1'b0;
    m_cmd_addr  = addr;
    m_cmd_wem   = 4'h0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Reset values
    settle();
    chk("rst_cmd_ready", 64'(m_cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(m_rsp_valid), 64'd0);
    chk("rst_rsp_error", 64'(m_rsp_error), 64'd0);
    chk("rst_rsp_rdata", 64'(m_rsp_rdata), 64'd0);
    chk("rst_s_cmd_valid", 64'(s_cmd_valid), 64'd0);
    chk("rst_s_rsp_ready", 64'(s_rsp_ready), 64'hF);
    adv();

    // Write to slave 1
    m_cmd_valid = 1'b1;
    m_cmd_we    = 1'b1;
    m_cmd_addr  = 32'h1000_0004;
    m_cmd_wdata = 32'hDEAD_BEEF;
    m_cmd_wem   = 4'hF;
    s_cmd_ready = 4'b0010;
    settle();
    chk("wr_s_cmd_valid", 64'(s_cmd_valid), 64'b0010);
    chk("wr_cmd_ready", 64'(m_cmd_ready), 64'd1);
    chk("wr_s_cmd_wdata", 64'(s_cmd_wdata), 64'hDEAD_BEEF);
    adv();
    idle_in();
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("wr_no_rsp", 64'(m_rsp_valid), 64'd0);
      adv();
    end

    // Read slave 2, response three cycles later
    issue_read(32'h2000_0000);
    s_cmd_ready = 4'b0100;
    settle();
    chk("rd2_cmd_ready", 64'(m_cmd_ready), 64'd1);
    adv();
    idle_in();
    step();
    step();
    s_rsp_valid = 4'b0100;
    s_rsp_rdata[64 +: 32] = 32'h1234_5678;
    settle();
    chk("rd2_rsp_valid", 64'(m_rsp_valid), 64'd1);
    chk("rd2_rsp_rdata", 64'(m_rsp_rdata), 64'h1234_5678);
    chk("rd2_rsp_error", 64'(m_rsp_error), 64'd0);
    adv();
    idle_in();
    settle();
    chk("rd2_back_idle", 64'(s_rsp_ready), 64'hF);
    adv();

    // Unmapped read, response held while master stalls
    issue_read(32'h5000_0000);
    m_rsp_ready = 1'b0;
    settle();
    chk("unm_cmd_ready", 64'(m_cmd_ready), 64'd1);
    adv();
    m_cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("unm_rsp", 64'({m_rsp_valid, m_rsp_error, m_rsp_rdata}), {30'd0, 2'b11, 32'd0});
      adv();
    end
    m_rsp_ready = 1'b1;
    settle();
    chk("unm_rsp_last", 64'({m_rsp_valid, m_rsp_error}), 64'b11);
    adv();
    settle();
    chk("unm_done", 64'(m_rsp_valid), 64'd0);
    adv();

`ifdef SBUS_TIMEOUT_EN
    // Silent slave 0: error after TO waiting cycles, stray response drained
    issue_read(32'h0000_0010);
    s_cmd_ready = 4'b0001;
    step();
    idle_in();
    for (int k = 0; k < TO; k++) begin
      settle();
      chk("tmo_wait", 64'(m_rsp_valid), 64'd0);
      adv();
    end
    settle();
    chk("tmo_err", 64'({m_rsp_valid, m_rsp_error, m_rsp_rdata}), {30'd0, 2'b11, 32'd0});
    adv();
    s_rsp_valid = 4'b0001;
    s_rsp_rdata[0 +: 32] = 32'hCAFE_0001;
    settle();
    chk("tmo_stray_rv", 64'(m_rsp_valid), 64'd0);
    chk("tmo_stray_drain", 64'(s_rsp_ready), 64'hF);
    adv();
    idle_in();

    // Response on the expiry cycle wins
    issue_read(32'h0000_0020);
    s_cmd_ready = 4'b0001;
    step();
    idle_in();
    for (int k = 0; k < TO - 1; k++) step();
    s_rsp_valid = 4'b0001;
    s_rsp_rdata[0 +: 32] = 32'hAABB_CCDD;
    settle();
    chk("exp_rsp", 64'({m_rsp_valid, m_rsp_error, m_rsp_rdata}), {30'd0, 2'b10, 32'hAABB_CCDD});
    adv();
    idle_in();
    settle();
    chk("exp_no_err", 64'(m_rsp_valid), 64'd0);
    adv();
`endif

    // Reset in the middle of a read
    issue_read(32'h1000_0000);
    s_cmd_ready = 4'b0010;
    step();
    idle_in();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("mid_rst_outs", 64'({m_cmd_ready, m_rsp_valid, m_rsp_error, s_cmd_valid, s_rsp_ready}),
        64'({1'b0, 1'b0, 1'b0, 4'b0000, 4'hF}));
    adv();
    issue_read(32'h3000_0008);
    s_cmd_ready = 4'b1000;
    settle();
    chk("rd3_cmd", 64'({m_cmd_ready, s_cmd_valid}), 64'b11000);
    adv();
    idle_in();
    s_rsp_valid = 4'b1000;
    s_rsp_rdata[96 +: 32] = 32'h0BAD_F00D;
    settle();
    chk("rd3_rsp", 64'({m_rsp_valid, m_rsp_error, m_rsp_rdata}), {30'd0, 2'b10, 32'h0BAD_F00D});
    adv();
    idle_in();

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst         = ($urandom_range(0, 249) == 0);
      m_cmd_valid = 1'($urandom);
      m_cmd_we    = 1'($urandom);
      m_cmd_addr  = {4'($urandom_range(0, 5)), 28'($urandom)};
      m_cmd_wdata = $urandom;
      m_cmd_wem   = 4'($urandom);
      s_cmd_ready = NS'($urandom);
      for (int i = 0; i < NS; i++) begin
        s_rsp_valid[i]        = ($urandom_range(0, 4) == 0);
        s_rsp_rdata[32*i +: 32] = $urandom;
      end
      s_rsp_error = NS'($urandom);
      m_rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
